// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction prefetch queue between a synchronous instruction ROM and the
// IF/ID pipeline register. It owns the fetch PC and issues one sequential ROM
// read at a time while there is room. Fetched {instruction, PC} pairs are
// buffered in a circular queue of DEPTH entries. The head entry is presented
// through a valid/ready handshake. A taken branch (flush) discards the
// buffered entries and any in-flight fetch, then restarts fetch at the
// branch target.
//
// State table:
//   IDLE     | reset, or go low with no read outstanding
//   RUN      | fetching or draining
//   REDIRECT | the single cycle after a flush; fetch_pc already holds target
//
// Ports:
//   clk             in   clock, rising edge
//   reset           in   synchronous active-low reset
//   go              in   fetch enable
//   rom_read_enable out  ROM read request this cycle
//   rom_addr        out  ROM read address (fetch PC)
//   rom_inst        in   ROM data, valid the cycle after the request
//   flush           in   taken branch; redirect fetch
//   flush_addr      in   branch target
//   out_valid       out  head entry valid
//   out_ready       in   consumer accepts head
//   out_inst        out  head instruction (0 when empty)
//   out_pc          out  head PC (0 when empty)
//   count           out  occupied entries

module fetch_queue #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [XLEN-1:0]       RESET_PC = '0,
  parameter logic [XLEN-1:0]       PC_STEP  = XLEN'(4)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  output logic                         rom_read_enable,
  output logic [XLEN-1:0]              rom_addr,
  input  logic [XLEN-1:0]              rom_inst,
  input  logic                         flush,
  input  logic [XLEN-1:0]              flush_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_inst,
  output logic [XLEN-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  logic [XLEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  logic            deq;
  logic            wr;
  logic            issue;
  logic [CW:0]     demand;

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready & ~flush;

  // Slots already committed (buffered plus the outstanding read) after this
  // cycle's dequeue; one extra bit so DEPTH itself is representable.
  assign demand = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);

  // The REDIRECT cycle may issue: the queue is already empty and fetch_pc
  // already holds the target, which gives the target at the head in F+3.
  // Reading during reset is suppressed since the response would be dropped.
  assign issue = reset & go & ~flush & (demand < (CW+1)'(DEPTH));

  assign rom_read_enable = issue;
  assign rom_addr        = fetch_pc;

  // A response arriving in a flush cycle belongs to the discarded path.
  assign wr = inflight & ~flush;

  assign out_inst = out_valid ? q_inst[head] : '0;
  assign out_pc   = out_valid ? q_pc[head]   : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (flush) begin
      state    <= REDIRECT;
      fetch_pc <= flush_addr;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      // At most one read outstanding: a response cycle clears inflight
      // unless a new read goes out in the same cycle.
      inflight <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end

      if (wr)  tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + CW'(wr) - CW'(deq);

      case (state)
        IDLE:     if (go) state <= RUN;
        RUN:      if (!go && !inflight) state <= IDLE;
        REDIRECT: state <= go ? RUN : IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (reset && wr) begin
      q_inst[tail] <= rom_inst;
      q_pc[tail]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            go;
  logic            flush;
  logic [XLEN-1:0] flush_addr;
  logic            out_ready;

  logic            ren_a, ren_b;
  logic [XLEN-1:0] addr_a, addr_b;
  logic [XLEN-1:0] rom_a = '0, rom_b = '0;
  logic            valid_a, valid_b;
  logic [XLEN-1:0] inst_a, inst_b;
  logic [XLEN-1:0] pc_a, pc_b;
  logic [CW-1:0]   cnt_a, cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .go(go),
    .rom_read_enable(ren_a), .rom_addr(addr_a), .rom_inst(rom_a),
    .flush(flush), .flush_addr(flush_addr),
    .out_valid(valid_a), .out_ready(out_ready),
    .out_inst(inst_a), .out_pc(pc_a), .count(cnt_a)
  );

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .reset(reset), .go(go),
    .rom_read_enable(ren_b), .rom_addr(addr_b), .rom_inst(rom_b),
    .flush(flush), .flush_addr(flush_addr),
    .out_valid(valid_b), .out_ready(out_ready),
    .out_inst(inst_b), .out_pc(pc_b), .count(cnt_b)
  );

  function automatic logic [XLEN-1:0] rom_word(input logic [XLEN-1:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  // Synchronous ROM models: data the cycle after the request.
  always @(posedge clk) begin
    if (ren_a) rom_a <= rom_word(addr_a);
    if (ren_b) rom_b <= rom_word(addr_b);
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_port(input string tag,
                          input logic av, input logic [XLEN-1:0] apc, input logic [XLEN-1:0] ainst,
                          input logic [CW-1:0] acnt, input logic aren, input logic [XLEN-1:0] aaddr,
                          input logic ev, input logic [XLEN-1:0] epc, input logic [CW-1:0] ecnt,
                          input logic eren, input logic [XLEN-1:0] eaddr);
    chk({tag, " out_valid"}, XLEN'(av), XLEN'(ev));
    chk({tag, " out_pc"}, apc, ev ? epc : '0);
    chk({tag, " out_inst"}, ainst, ev ? rom_word(epc) : '0);
    chk({tag, " count"}, XLEN'(acnt), XLEN'(ecnt));
    chk({tag, " rom_read_enable"}, XLEN'(aren), XLEN'(eren));
    chk({tag, " rom_addr"}, aaddr, eaddr);
  endtask

  task automatic chk_a(input string tag, input logic ev, input logic [XLEN-1:0] epc,
                       input logic [CW-1:0] ecnt, input logic eren, input logic [XLEN-1:0] eaddr);
    chk_port(tag, valid_a, pc_a, inst_a, cnt_a, ren_a, addr_a, ev, epc, ecnt, eren, eaddr);
  endtask

  task automatic chk_b(input string tag, input logic ev, input logic [XLEN-1:0] epc,
                       input logic [CW-1:0] ecnt, input logic eren, input logic [XLEN-1:0] eaddr);
    chk_port(tag, valid_b, pc_b, inst_b, cnt_b, ren_b, addr_b, ev, epc, ecnt, eren, eaddr);
  endtask

  // One cycle: drive inputs just after the falling edge, let combinational
  // outputs settle, then return for checking before the next rising edge.
  task automatic cyc(input logic g, input logic rdy, input logic fl,
                     input logic [XLEN-1:0] fa, input logic rst);
    @(negedge clk);
    reset      = rst;
    go         = g;
    out_ready  = rdy;
    flush      = fl;
    flush_addr = fa;
    #1;
  endtask

  typedef struct {
    logic            go;
    logic            rdy;
    logic            fl;
    logic [XLEN-1:0] fa;
    logic            v;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   cnt;
    logic            ren;
    logic [XLEN-1:0] addr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic g, input logic rdy, input logic fl, input logic [XLEN-1:0] fa,
                              input logic v, input logic [XLEN-1:0] pc, input logic [CW-1:0] cnt,
                              input logic ren, input logic [XLEN-1:0] addr);
    vec_t r;
    r.go = g; r.rdy = rdy; r.fl = fl; r.fa = fa;
    r.v = v; r.pc = pc; r.cnt = cnt; r.ren = ren; r.addr = addr;
    return r;
  endfunction

  initial begin
    //                go rdy fl  fa         v  pc         cnt ren addr
    vecs[0]  = mk(1, 1, 0, 32'h00, 0, 32'h00, 0, 1, 32'h00);
    vecs[1]  = mk(1, 1, 0, 32'h00, 0, 32'h00, 0, 1, 32'h04);
    vecs[2]  = mk(1, 1, 0, 32'h00, 1, 32'h00, 1, 1, 32'h08);
    vecs[3]  = mk(1, 1, 0, 32'h00, 1, 32'h04, 1, 1, 32'h0C);
    vecs[4]  = mk(1, 1, 0, 32'h00, 1, 32'h08, 1, 1, 32'h10);
    vecs[5]  = mk(1, 1, 0, 32'h00, 1, 32'h0C, 1, 1, 32'h14);
    // decode stall: queue fills, issue stops at count+inflight = DEPTH
    vecs[6]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 1, 1, 32'h18);
    vecs[7]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 2, 1, 32'h1C);
    vecs[8]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 3, 0, 32'h20);
    vecs[9]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 4, 0, 32'h20);
    vecs[10] = mk(1, 0, 0, 32'h00, 1, 32'h10, 4, 0, 32'h20);
    // release: issue resumes in the same cycle as the first dequeue
    vecs[11] = mk(1, 1, 0, 32'h00, 1, 32'h10, 4, 1, 32'h20);
    vecs[12] = mk(1, 1, 0, 32'h00, 1, 32'h14, 3, 1, 32'h24);
    vecs[13] = mk(1, 1, 0, 32'h00, 1, 32'h18, 3, 1, 32'h28);
    vecs[14] = mk(1, 1, 0, 32'h00, 1, 32'h1C, 3, 1, 32'h2C);
    // flush with three entries buffered and 0x2C in flight
    vecs[15] = mk(1, 1, 1, 32'h40, 1, 32'h20, 3, 0, 32'h30);
    vecs[16] = mk(1, 1, 0, 32'h00, 0, 32'h00, 0, 1, 32'h40);
    vecs[17] = mk(1, 1, 0, 32'h00, 0, 32'h00, 0, 1, 32'h44);
    vecs[18] = mk(1, 1, 0, 32'h00, 1, 32'h40, 1, 1, 32'h48);
    vecs[19] = mk(1, 1, 0, 32'h00, 1, 32'h44, 1, 1, 32'h4C);

    reset      = 1'b0;
    go         = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    flush_addr = '0;

    // reset held low across two rising edges; check after the first
    @(negedge clk);
    #1;
    chk_a("reset", 0, 32'h0, 0, 0, 32'h0000_0000);
    chk_b("reset_wrap", 0, 32'h0, 0, 0, 32'hFFFF_FFF8);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].go, vecs[i].rdy, vecs[i].fl, vecs[i].fa, 1'b1);
      chk_a($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].cnt, vecs[i].ren, vecs[i].addr);
    end

    // go dropped with 0x4C in flight: it is still enqueued, then the queue drains
    cyc(0, 0, 0, 32'h0, 1); chk_a("godrop0", 1, 32'h48, 1, 0, 32'h50);
    cyc(0, 0, 0, 32'h0, 1); chk_a("godrop1", 1, 32'h48, 2, 0, 32'h50);
    cyc(0, 1, 0, 32'h0, 1); chk_a("drain0",  1, 32'h48, 2, 0, 32'h50);
    cyc(0, 1, 0, 32'h0, 1); chk_a("drain1",  1, 32'h4C, 1, 0, 32'h50);
    cyc(0, 1, 0, 32'h0, 1); chk_a("drain2",  0, 32'h0,  0, 0, 32'h50);
    cyc(0, 1, 0, 32'h0, 1); chk_a("idle",    0, 32'h0,  0, 0, 32'h50);

    // build up three entries plus a read in flight, then reset
    cyc(1, 0, 0, 32'h0, 1); chk_a("fill0", 0, 32'h0,  0, 1, 32'h50);
    cyc(1, 0, 0, 32'h0, 1); chk_a("fill1", 0, 32'h0,  0, 1, 32'h54);
    cyc(1, 0, 0, 32'h0, 1); chk_a("fill2", 1, 32'h50, 1, 1, 32'h58);
    cyc(1, 0, 0, 32'h0, 1); chk_a("fill3", 1, 32'h50, 2, 1, 32'h5C);
    cyc(1, 0, 0, 32'h0, 0); chk("pre_reset count", XLEN'(cnt_a), XLEN'(3));
    cyc(0, 0, 0, 32'h0, 0);
    chk_a("in_reset", 0, 32'h0, 0, 0, 32'h0000_0000);
    chk_b("in_reset_wrap", 0, 32'h0, 0, 0, 32'hFFFF_FFF8);

    // restart from RESET_PC on both instances; the second wraps past 2^32
    cyc(1, 1, 0, 32'h0, 1);
    chk_a("restart0", 0, 32'h0, 0, 1, 32'h0000_0000);
    chk_b("wrap_r0",  0, 32'h0, 0, 1, 32'hFFFF_FFF8);
    cyc(1, 1, 0, 32'h0, 1);
    chk_a("restart1", 0, 32'h0, 0, 1, 32'h0000_0004);
    chk_b("wrap_r1",  0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    for (int k = 0; k < 12; k++) begin
      cyc(1, 1, 0, 32'h0, 1);
      chk_a($sformatf("stream%0d", k), 1, 32'(4 * k), 1, 1, 32'(4 * (k + 2)));
      chk_b($sformatf("wrap%0d", k), 1, 32'hFFFF_FFF8 + 32'(4 * k), 1, 1,
            32'hFFFF_FFF8 + 32'(4 * (k + 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
